// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: decode stage between IF and EX.
// Holds the IF/ID and ID/EX registers, extracts register/immediate fields,
// bypasses the WB write port into operand reads, detects load-use hazards,
// resolves jumps in ID (squashing the delay slot) and inserts bubbles on
// stall or flush. Opcode/funct decode lives in an external control unit whose
// outputs come back in through the ctrl_* ports and are pipelined to EX.
module id_stage_pipelined #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int RF_SIZE    = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // fetched slot
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [PC_WIDTH-1:0]   if_next_pc,
    output logic                  if_hold,
    // to / from control unit
    output logic [5:0]            opcode,
    output logic [5:0]            funct,
    input  logic [CTRL_WIDTH-1:0] ctrl_word,
    input  logic                  ctrl_is_load,
    input  logic                  ctrl_is_jump,
    input  logic                  ctrl_sel_j_jr,
    input  logic                  ctrl_uses_rt,
    input  logic                  ctrl_imm_zext,
    input  logic [1:0]            ctrl_dst_sel,
    // register file read port
    output logic [ADDR_WIDTH-1:0] rf_rs,
    output logic [ADDR_WIDTH-1:0] rf_rt,
    input  logic [DATA_WIDTH-1:0] rf_data_rs,
    input  logic [DATA_WIDTH-1:0] rf_data_rt,
    // WB write port, used as bypass source
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    // pipeline control
    input  logic                  ext_stall,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  jump_valid,
    output logic [PC_WIDTH-1:0]   jump_addr,
    // ID/EX register outputs
    output logic                  ex_valid,
    output logic                  ex_is_load,
    output logic [CTRL_WIDTH-1:0] ex_ctrl,
    output logic [ADDR_WIDTH-1:0] ex_rs,
    output logic [ADDR_WIDTH-1:0] ex_rt,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic [ADDR_WIDTH-1:0] ex_dst,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [DATA_WIDTH-1:0] ex_data_rs,
    output logic [DATA_WIDTH-1:0] ex_data_rt,
    output logic [PC_WIDTH-1:0]   ex_next_pc
);

    // Highest physical register index; also the link register.
    localparam logic [ADDR_WIDTH-1:0] RF_MAX = ADDR_WIDTH'(RF_SIZE - 1);

    // Register field values beyond the physical file map onto its top entry.
    function automatic logic [ADDR_WIDTH-1:0] clamp_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a > RF_MAX) ? RF_MAX : a;
    endfunction

    // 16-bit immediate to operand width, signed unless zero-extension is asked for.
    function automatic logic [DATA_WIDTH-1:0] extend_imm(input logic [15:0] imm,
                                                         input logic       zext);
        logic signed [15:0] imm_s;
        imm_s = imm;
        if (zext)
            return DATA_WIDTH'(imm);
        else
            return DATA_WIDTH'(imm_s);
    endfunction

    // WB-to-ID bypass: a same-cycle write to the register being read wins.
    function automatic logic [DATA_WIDTH-1:0] bypass(input logic                  we,
                                                     input logic [ADDR_WIDTH-1:0] waddr,
                                                     input logic [DATA_WIDTH-1:0] wdata,
                                                     input logic [ADDR_WIDTH-1:0] raddr,
                                                     input logic [DATA_WIDTH-1:0] rdata);
        return (we && (waddr == raddr)) ? wdata : rdata;
    endfunction

    // ------------------------------------------------------------------
    // IF/ID register (stage p0)
    // ------------------------------------------------------------------
    logic                  id_vld_p0;
    logic [31:0]           id_instr_p0;
    logic [PC_WIDTH-1:0]   id_pc_p0;

    // Decoded fields of the instruction sitting in ID.
    logic [ADDR_WIDTH-1:0] rs_raw;
    logic [ADDR_WIDTH-1:0] rt_raw;
    logic [ADDR_WIDTH-1:0] rd_raw;
    logic [ADDR_WIDTH-1:0] rs_idx;
    logic [ADDR_WIDTH-1:0] rt_idx;
    logic [15:0]           imm16;
    logic [25:0]           target26;
    logic [DATA_WIDTH-1:0] op_rs;
    logic [DATA_WIDTH-1:0] op_rt;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [ADDR_WIDTH-1:0] dst_sel_addr;

    // Pipeline steering.
    logic                  issue_p0;
    logic                  ex_advance;

    // ------------------------------------------------------------------
    // ID/EX register (stage p1)
    // ------------------------------------------------------------------
    logic                  ex_vld_p1;
    logic                  ex_load_p1;
    logic [CTRL_WIDTH-1:0] ex_ctrl_p1;
    logic [ADDR_WIDTH-1:0] ex_rs_p1;
    logic [ADDR_WIDTH-1:0] ex_rt_p1;
    logic [ADDR_WIDTH-1:0] ex_rd_p1;
    logic [ADDR_WIDTH-1:0] ex_dst_p1;
    logic [DATA_WIDTH-1:0] ex_imm_p1;
    logic [DATA_WIDTH-1:0] ex_data_rs_p1;
    logic [DATA_WIDTH-1:0] ex_data_rt_p1;
    logic [PC_WIDTH-1:0]   ex_next_pc_p1;

    assign rs_raw   = ADDR_WIDTH'(id_instr_p0[25:21]);
    assign rt_raw   = ADDR_WIDTH'(id_instr_p0[20:16]);
    assign rd_raw   = ADDR_WIDTH'(id_instr_p0[15:11]);
    assign imm16    = id_instr_p0[15:0];
    assign target26 = id_instr_p0[25:0];

    assign opcode   = id_instr_p0[31:26];
    assign funct    = id_instr_p0[5:0];

    assign rs_idx   = clamp_addr(rs_raw);
    assign rt_idx   = clamp_addr(rt_raw);
    assign rf_rs    = rs_idx;
    assign rf_rt    = rt_idx;

    assign op_rs    = bypass(wb_we, wb_addr, wb_data, rs_idx, rf_data_rs);
    assign op_rt    = bypass(wb_we, wb_addr, wb_data, rt_idx, rf_data_rt);
    assign imm_ext  = extend_imm(imm16, ctrl_imm_zext);

    // Destination register select: rt, rd or the link register.
    always_comb begin
        dst_sel_addr = rt_idx;
        case (ctrl_dst_sel)
            2'd0:    dst_sel_addr = rt_idx;
            2'd1:    dst_sel_addr = clamp_addr(rd_raw);
            2'd2:    dst_sel_addr = RF_MAX;
            default: dst_sel_addr = rt_idx;
        endcase
    end

    // A load in EX whose destination is read in ID costs one bubble.
    assign hazard_stall = id_vld_p0 & ex_vld_p1 & ex_load_p1 &
                          ((ex_dst_p1 == rs_idx) | (ctrl_uses_rt & (ex_dst_p1 == rt_idx)));

    assign if_hold      = ext_stall | hazard_stall;

    assign jump_valid   = id_vld_p0 & ctrl_is_jump & ~hazard_stall & ~ext_stall & ~flush;
    assign jump_addr    = ctrl_sel_j_jr ? PC_WIDTH'(target26) : PC_WIDTH'(op_rs);

    // ID hands a real instruction to EX only when nothing blocks it; EX
    // accepts a new value (instruction or bubble) unless stalled, and a
    // flush always forces the bubble through.
    assign issue_p0     = id_vld_p0 & ~hazard_stall & ~ext_stall & ~flush;
    assign ex_advance   = flush | ~ext_stall;

    // IF/ID register: flush clears, hold keeps, a taken jump squashes the delay slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_vld_p0   <= 1'b0;
            id_instr_p0 <= '0;
            id_pc_p0    <= '0;
        end else if (flush) begin
            id_vld_p0   <= 1'b0;
        end else if (!if_hold) begin
            if (jump_valid) begin
                id_vld_p0   <= 1'b0;
            end else begin
                id_vld_p0   <= if_valid;
                id_instr_p0 <= if_instr;
                id_pc_p0    <= if_next_pc;
            end
        end
    end

    // ID/EX control bits: a bubble clears valid, load flag and control bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_p1  <= 1'b0;
            ex_load_p1 <= 1'b0;
            ex_ctrl_p1 <= '0;
        end else if (ex_advance) begin
            ex_vld_p1  <= issue_p0;
            ex_load_p1 <= issue_p0 & ctrl_is_load;
            ex_ctrl_p1 <= issue_p0 ? ctrl_word : '0;
        end
    end

    // ID/EX data fields: loaded only on issue, otherwise they keep their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs_p1      <= '0;
            ex_rt_p1      <= '0;
            ex_rd_p1      <= '0;
            ex_dst_p1     <= '0;
            ex_imm_p1     <= '0;
            ex_data_rs_p1 <= '0;
            ex_data_rt_p1 <= '0;
            ex_next_pc_p1 <= '0;
        end else if (issue_p0) begin
            ex_rs_p1      <= rs_raw;
            ex_rt_p1      <= rt_raw;
            ex_rd_p1      <= rd_raw;
            ex_dst_p1     <= dst_sel_addr;
            ex_imm_p1     <= imm_ext;
            ex_data_rs_p1 <= op_rs;
            ex_data_rt_p1 <= op_rt;
            ex_next_pc_p1 <= id_pc_p0;
        end
    end

    assign ex_valid   = ex_vld_p1;
    assign ex_is_load = ex_load_p1;
    assign ex_ctrl    = ex_ctrl_p1;
    assign ex_rs      = ex_rs_p1;
    assign ex_rt      = ex_rt_p1;
    assign ex_rd      = ex_rd_p1;
    assign ex_dst     = ex_dst_p1;
    assign ex_imm     = ex_imm_p1;
    assign ex_data_rs = ex_data_rs_p1;
    assign ex_data_rt = ex_data_rt_p1;
    assign ex_next_pc = ex_next_pc_p1;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb_id_stage_pipelined: directed bench for id_stage_pipelined with a
// scoreboard of expected ID/EX contents.
module tb_id_stage_pipelined;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_next_pc;
    logic        if_hold;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [19:0] ctrl_word;
    logic        ctrl_is_load;
    logic        ctrl_is_jump;
    logic        ctrl_sel_j_jr;
    logic        ctrl_uses_rt;
    logic        ctrl_imm_zext;
    logic [1:0]  ctrl_dst_sel;
    logic [4:0]  rf_rs;
    logic [4:0]  rf_rt;
    logic [31:0] rf_data_rs;
    logic [31:0] rf_data_rt;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ext_stall;
    logic        flush;
    logic        hazard_stall;
    logic        jump_valid;
    logic [31:0] jump_addr;
    logic        ex_valid;
    logic        ex_is_load;
    logic [19:0] ex_ctrl;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_dst;
    logic [31:0] ex_imm;
    logic [31:0] ex_data_rs;
    logic [31:0] ex_data_rt;
    logic [31:0] ex_next_pc;

    id_stage_pipelined #(
        .DATA_WIDTH(32), .PC_WIDTH(32), .RF_SIZE(16), .ADDR_WIDTH(5), .CTRL_WIDTH(20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_next_pc(if_next_pc), .if_hold(if_hold),
        .opcode(opcode), .funct(funct),
        .ctrl_word(ctrl_word), .ctrl_is_load(ctrl_is_load), .ctrl_is_jump(ctrl_is_jump),
        .ctrl_sel_j_jr(ctrl_sel_j_jr), .ctrl_uses_rt(ctrl_uses_rt),
        .ctrl_imm_zext(ctrl_imm_zext), .ctrl_dst_sel(ctrl_dst_sel),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_data_rs(rf_data_rs), .rf_data_rt(rf_data_rt),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ext_stall(ext_stall), .flush(flush),
        .hazard_stall(hazard_stall), .jump_valid(jump_valid), .jump_addr(jump_addr),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_dst(ex_dst),
        .ex_imm(ex_imm), .ex_data_rs(ex_data_rs), .ex_data_rt(ex_data_rt),
        .ex_next_pc(ex_next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] ctrl;
        logic        is_load;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [31:0] drs;
        logic [31:0] drt;
        logic [31:0] pc;
    } ex_exp_t;

    ex_exp_t sb_q[$];
    ex_exp_t last_exp;
    int      checks = 0;
    int      errors = 0;

    localparam logic [31:0] I_ADDI = 32'h2022_FFFE; // rs=1 rt=2 rd=31 imm=FFFE
    localparam logic [31:0] I_LW   = 32'h8C03_0010; // rs=0 rt=3 imm=0x10
    localparam logic [31:0] I_USE  = 32'h0064_2820; // rs=3 rt=4 rd=5
    localparam logic [31:0] I_NOST = 32'h2023_0007; // rs=1 rt=3
    localparam logic [31:0] I_BYP  = 32'h00A6_3820; // rs=5 rt=6 rd=7
    localparam logic [31:0] I_J    = 32'h0800_0100; // target 0x100
    localparam logic [31:0] I_SLOT = 32'h2022_0001;
    localparam logic [31:0] I_JR   = 32'h03E0_0008; // rs=31
    localparam logic [31:0] I_X    = 32'h2022_0005;
    localparam logic [31:0] I_Y    = 32'h2022_0006;

    function automatic logic [4:0] clampf(input logic [4:0] a);
        return (a > 5'd15) ? 5'd15 : a;
    endfunction

    function automatic ex_exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [19:0] cw, input logic ld,
                                      input logic [1:0] dsel, input logic zext,
                                      input logic [31:0] drs, input logic [31:0] drt);
        ex_exp_t m;
        m.ctrl    = cw;
        m.is_load = ld;
        m.rs      = instr[25:21];
        m.rt      = instr[20:16];
        m.rd      = instr[15:11];
        case (dsel)
            2'd1:    m.dst = clampf(instr[15:11]);
            2'd2:    m.dst = 5'd15;
            default: m.dst = clampf(instr[20:16]);
        endcase
        m.imm = zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
        m.drs = drs;
        m.drt = drt;
        m.pc  = pc;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_if(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid   = v;
        if_instr   = instr;
        if_next_pc = pc;
    endtask

    task automatic set_ctrl(input logic [19:0] cw, input logic ld, input logic jmp,
                            input logic selj, input logic urt, input logic zext,
                            input logic [1:0] dsel);
        ctrl_word     = cw;
        ctrl_is_load  = ld;
        ctrl_is_jump  = jmp;
        ctrl_sel_j_jr = selj;
        ctrl_uses_rt  = urt;
        ctrl_imm_zext = zext;
        ctrl_dst_sel  = dsel;
    endtask

    task automatic cmp_fields(input string tag, input ex_exp_t e);
        chk({tag, ".valid"}, 64'(ex_valid), 64'(1'b1));
        chk({tag, ".ctrl"},  64'(ex_ctrl), 64'(e.ctrl));
        chk({tag, ".load"},  64'(ex_is_load), 64'(e.is_load));
        chk({tag, ".rs"},    64'(ex_rs), 64'(e.rs));
        chk({tag, ".rt"},    64'(ex_rt), 64'(e.rt));
        chk({tag, ".rd"},    64'(ex_rd), 64'(e.rd));
        chk({tag, ".dst"},   64'(ex_dst), 64'(e.dst));
        chk({tag, ".imm"},   64'(ex_imm), 64'(e.imm));
        chk({tag, ".drs"},   64'(ex_data_rs), 64'(e.drs));
        chk({tag, ".drt"},   64'(ex_data_rt), 64'(e.drt));
        chk({tag, ".pc"},    64'(ex_next_pc), 64'(e.pc));
    endtask

    task automatic check_ex_pop(input string tag);
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end
        if (sb_q.size() != 0) begin
            last_exp = sb_q.pop_front();
            cmp_fields(tag, last_exp);
        end
    endtask

    // Drive one instruction through IF, ID and EX with no neighbours.
    task automatic issue_simple(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                                input logic [19:0] cw, input logic urt, input logic zext,
                                input logic [1:0] dsel, input logic [31:0] rs_in,
                                input logic [31:0] rt_in, input logic [31:0] exp_rs,
                                input logic [31:0] exp_rt);
        drive_if(1'b1, instr, pc);
        tick();
        set_ctrl(cw, 1'b0, 1'b0, 1'b0, urt, zext, dsel);
        rf_data_rs = rs_in;
        rf_data_rt = rt_in;
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        chk({tag, ".hz"}, 64'(hazard_stall), 64'(1'b0));
        sb_q.push_back(model(instr, pc, cw, 1'b0, dsel, zext, exp_rs, exp_rt));
        tick();
        check_ex_pop(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive_if(1'b0, 32'h0, 32'h0);
        set_ctrl(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        rf_data_rs = 32'h0;
        rf_data_rt = 32'h0;
        wb_we      = 1'b0;
        wb_addr    = 5'd0;
        wb_data    = 32'h0;
        ext_stall  = 1'b0;
        flush      = 1'b0;

        // Reset state
        #12;
        chk("rst.valid", 64'(ex_valid), 64'(1'b0));
        chk("rst.ctrl",  64'(ex_ctrl), 64'(20'h0));
        chk("rst.imm",   64'(ex_imm), 64'(32'h0));
        chk("rst.pc",    64'(ex_next_pc), 64'(32'h0));
        chk("rst.op",    64'(opcode), 64'(6'h0));
        chk("rst.hold",  64'(if_hold), 64'(1'b0));
        chk("rst.jv",    64'(jump_valid), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Straight-line, sign-extended immediate, dst = rt
        drive_if(1'b1, I_ADDI, 32'h104);
        tick();
        set_ctrl(20'h12345, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        rf_data_rs = 32'h1111_1111;
        rf_data_rt = 32'h2222_2222;
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        chk("dec.op",    64'(opcode), 64'(6'h08));
        chk("dec.funct", 64'(funct), 64'(6'h3E));
        chk("dec.rs",    64'(rf_rs), 64'(5'd1));
        chk("dec.rt",    64'(rf_rt), 64'(5'd2));
        sb_q.push_back(model(I_ADDI, 32'h104, 20'h12345, 1'b0, 2'd0, 1'b0,
                             32'h1111_1111, 32'h2222_2222));
        tick();
        check_ex_pop("sext");

        // Zero-extended immediate, dst = rd (31 clamps to 15)
        issue_simple("zext", I_ADDI, 32'h108, 20'h00F0F, 1'b1, 1'b1, 2'd1,
                     32'h0000_00AA, 32'h0000_00BB, 32'h0000_00AA, 32'h0000_00BB);
        // Bubble: control cleared, data held
        tick();
        chk("bub.valid", 64'(ex_valid), 64'(1'b0));
        chk("bub.ctrl",  64'(ex_ctrl), 64'(20'h0));
        chk("bub.imm",   64'(ex_imm), 64'(last_exp.imm));

        // Load-use: LW r3 then a consumer of r3
        drive_if(1'b1, I_LW, 32'h200);
        tick();
        set_ctrl(20'hABCDE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        rf_data_rs = 32'h0000_1000;
        rf_data_rt = 32'h0000_3333;
        drive_if(1'b1, I_USE, 32'h204);
        #1;
        chk("lu.pre_hz", 64'(hazard_stall), 64'(1'b0));
        sb_q.push_back(model(I_LW, 32'h200, 20'hABCDE, 1'b1, 2'd0, 1'b0,
                             32'h0000_1000, 32'h0000_3333));
        tick();
        check_ex_pop("lu.load");
        set_ctrl(20'h00C0C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        rf_data_rs = 32'h0000_0005;
        rf_data_rt = 32'h0000_0006;
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        chk("lu.hz",   64'(hazard_stall), 64'(1'b1));
        chk("lu.hold", 64'(if_hold), 64'(1'b1));
        tick();
        chk("lu.bub_valid", 64'(ex_valid), 64'(1'b0));
        chk("lu.bub_load",  64'(ex_is_load), 64'(1'b0));
        chk("lu.bub_dst",   64'(ex_dst), 64'(5'd3));
        chk("lu.release",   64'(hazard_stall), 64'(1'b0));
        chk("lu.id_rs",     64'(rf_rs), 64'(5'd3));
        sb_q.push_back(model(I_USE, 32'h204, 20'h00C0C, 1'b0, 2'd1, 1'b0,
                             32'h0000_0005, 32'h0000_0006));
        tick();
        check_ex_pop("lu.use");

        // Load followed by rt=3 reader that does not use rt: no stall
        drive_if(1'b1, I_LW, 32'h300);
        tick();
        set_ctrl(20'hABCDE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive_if(1'b1, I_NOST, 32'h304);
        #1;
        sb_q.push_back(model(I_LW, 32'h300, 20'hABCDE, 1'b1, 2'd0, 1'b0,
                             rf_data_rs, rf_data_rt));
        tick();
        check_ex_pop("ns.load");
        set_ctrl(20'h00777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        chk("ns.rt", 64'(rf_rt), 64'(5'd3));
        chk("ns.hz", 64'(hazard_stall), 64'(1'b0));
        sb_q.push_back(model(I_NOST, 32'h304, 20'h00777, 1'b0, 2'd0, 1'b0,
                             rf_data_rs, rf_data_rt));
        tick();
        check_ex_pop("ns.use");

        // WB bypass on rs, then on rt
        wb_we   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'hDEAD_BEEF;
        issue_simple("byp.rs", I_BYP, 32'h400, 20'h0BEEF, 1'b1, 1'b0, 2'd1,
                     32'h0, 32'h0000_0066, 32'hDEAD_BEEF, 32'h0000_0066);
        wb_addr = 5'd6;
        wb_data = 32'hCAFE_F00D;
        issue_simple("byp.rt", I_BYP, 32'h408, 20'h0BEEF, 1'b1, 1'b0, 2'd1,
                     32'h0000_0055, 32'h0, 32'h0000_0055, 32'hCAFE_F00D);
        wb_we = 1'b0;

        // Jump with target, delay slot squashed, link destination
        drive_if(1'b1, I_J, 32'h500);
        tick();
        set_ctrl(20'h00A0A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
        rf_data_rs = 32'h0000_0077;
        rf_data_rt = 32'h0000_0088;
        drive_if(1'b1, I_SLOT, 32'h504);
        #1;
        chk("j.valid", 64'(jump_valid), 64'(1'b1));
        chk("j.addr",  64'(jump_addr), 64'(32'h100));
        chk("j.hold",  64'(if_hold), 64'(1'b0));
        sb_q.push_back(model(I_J, 32'h500, 20'h00A0A, 1'b0, 2'd2, 1'b0,
                             32'h0000_0077, 32'h0000_0088));
        tick();
        check_ex_pop("j.ex");
        set_ctrl(20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        chk("j.squash_id", 64'(jump_valid), 64'(1'b0));
        tick();
        chk("j.slot", 64'(ex_valid), 64'(1'b0));
        set_ctrl(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Jump register on rs=31 (reads clamped r15)
        drive_if(1'b1, I_JR, 32'h600);
        tick();
        set_ctrl(20'h00008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        rf_data_rs = 32'h0000_4444;
        rf_data_rt = 32'h0000_0001;
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        chk("jr.rf_rs", 64'(rf_rs), 64'(5'd15));
        chk("jr.valid", 64'(jump_valid), 64'(1'b1));
        chk("jr.addr",  64'(jump_addr), 64'(32'h0000_4444));
        sb_q.push_back(model(I_JR, 32'h600, 20'h00008, 1'b0, 2'd0, 1'b0,
                             32'h0000_4444, 32'h0000_0001));
        tick();
        check_ex_pop("jr.ex");
        set_ctrl(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Flush together with ext_stall: both stages empty
        drive_if(1'b1, I_X, 32'h700);
        tick();
        set_ctrl(20'h11111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        rf_data_rs = 32'h1;
        rf_data_rt = 32'h2;
        drive_if(1'b1, I_Y, 32'h704);
        #1;
        sb_q.push_back(model(I_X, 32'h700, 20'h11111, 1'b0, 2'd0, 1'b0, 32'h1, 32'h2));
        tick();
        check_ex_pop("fl.x");
        ext_stall = 1'b1;
        flush     = 1'b1;
        #1;
        chk("fl.hold", 64'(if_hold), 64'(1'b1));
        tick();
        ext_stall = 1'b0;
        flush     = 1'b0;
        set_ctrl(20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        chk("fl.ex_valid", 64'(ex_valid), 64'(1'b0));
        chk("fl.ex_ctrl",  64'(ex_ctrl), 64'(20'h0));
        chk("fl.id_jv",    64'(jump_valid), 64'(1'b0));
        tick();
        chk("fl.id_empty", 64'(ex_valid), 64'(1'b0));
        set_ctrl(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // ext_stall alone holds EX for three cycles and keeps ID
        drive_if(1'b1, I_X, 32'h800);
        tick();
        set_ctrl(20'h22222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        rf_data_rs = 32'hA;
        rf_data_rt = 32'hB;
        drive_if(1'b1, I_Y, 32'h804);
        #1;
        sb_q.push_back(model(I_X, 32'h800, 20'h22222, 1'b0, 2'd0, 1'b0, 32'hA, 32'hB));
        tick();
        check_ex_pop("st.x");
        ext_stall = 1'b1;
        set_ctrl(20'h33333, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        rf_data_rs = 32'hC;
        rf_data_rt = 32'hD;
        drive_if(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp_fields("st.hold", last_exp);
        end
        ext_stall = 1'b0;
        #1;
        sb_q.push_back(model(I_Y, 32'h804, 20'h33333, 1'b0, 2'd0, 1'b0, 32'hC, 32'hD));
        tick();
        check_ex_pop("st.y");

        // Asynchronous reset mid-stream clears everything immediately
        drive_if(1'b1, I_X, 32'h900);
        tick();
        set_ctrl(20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        chk("ar.pre_jv", 64'(jump_valid), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("ar.valid", 64'(ex_valid), 64'(1'b0));
        chk("ar.imm",   64'(ex_imm), 64'(32'h0));
        chk("ar.drs",   64'(ex_data_rs), 64'(32'h0));
        chk("ar.pc",    64'(ex_next_pc), 64'(32'h0));
        chk("ar.dst",   64'(ex_dst), 64'(5'd0));
        chk("ar.hold",  64'(if_hold), 64'(1'b0));
        chk("ar.jv",    64'(jump_valid), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        set_ctrl(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        tick();
        chk("ar.restart", 64'(ex_valid), 64'(1'b0));

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb.drain: observed %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
